// File: rtl/sum_accumulator.sv
// Accumulates a bounded run of adder results into an 8-bit sum.
// Carry and overflow are sticky across the run.
module sum_accumulator #(
    parameter int unsigned MAX_OPS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] op_count,
    input  logic       in_valid,
    input  logic [7:0] in_result,
    input  logic       in_carry,
    input  logic       in_overflow,
    output logic       in_ready,
    output logic [7:0] acc,
    output logic       f_carry,
    output logic       f_overflow,
    output logic       f_negativo,
    output logic       f_zero,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OPS);

    state_t     state;
    logic [3:0] remaining;
    logic [3:0] count_clamped;
    logic [8:0] sum9;
    logic       add_ovf;
    logic       xfer;

    assign count_clamped = (op_count > MAX_CNT) ? MAX_CNT : op_count;
    assign sum9          = {1'b0, acc} + {1'b0, in_result};
    assign add_ovf       = (acc[7] == in_result[7]) && (sum9[7] != acc[7]);
    assign xfer          = in_ready && in_valid;

    assign f_negativo = acc[7];
    assign f_zero     = (acc == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= 4'd0;
            acc        <= 8'h00;
            f_carry    <= 1'b0;
            f_overflow <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= 8'h00;
                        f_carry    <= 1'b0;
                        f_overflow <= 1'b0;
                        remaining  <= count_clamped;
                        busy       <= 1'b1;
                        // An empty run skips straight to the completion pulse
                        if (count_clamped == 4'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc        <= sum9[7:0];
                        f_carry    <= f_carry | in_carry | sum9[8];
                        f_overflow <= f_overflow | in_overflow | add_ovf;
                        remaining  <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator with a cycle-level reference model.
// Small MAX_OPS so the clamp path is reachable with a 4-bit count.
module tb_sum_accumulator;

    localparam int MAXP = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op_count = 4'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_result = 8'h00;
    logic       in_carry = 1'b0;
    logic       in_overflow = 1'b0;
    logic       in_ready;
    logic [7:0] acc;
    logic       f_carry, f_overflow, f_negativo, f_zero;
    logic       busy, done;

    sum_accumulator #(.MAX_OPS(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_count(op_count),
        .in_valid(in_valid), .in_result(in_result), .in_carry(in_carry),
        .in_overflow(in_overflow), .in_ready(in_ready), .acc(acc),
        .f_carry(f_carry), .f_overflow(f_overflow),
        .f_negativo(f_negativo), .f_zero(f_zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Reference model: operands still owed, a pending done pulse,
    // and the sum / sticky flags computed with plain integers.
    int left = 0;
    bit m_done = 1'b0;
    int m_acc = 0;
    bit m_c = 1'b0;
    bit m_v = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            left = 0; m_done = 0; m_acc = 0; m_c = 0; m_v = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (left > 0) begin
            if (in_valid) begin
                int u, a, b;
                u = m_acc + int'(in_result);
                a = (m_acc > 127) ? m_acc - 256 : m_acc;
                b = (in_result > 127) ? int'(in_result) - 256 : int'(in_result);
                if (u > 255 || in_carry) m_c = 1;
                if (a + b > 127 || a + b < -128 || in_overflow) m_v = 1;
                m_acc = u % 256;
                left--;
                if (left == 0) m_done = 1;
            end
        end else if (start) begin
            m_acc = 0; m_c = 0; m_v = 0;
            left = (int'(op_count) > MAXP) ? MAXP : int'(op_count);
            if (left == 0) m_done = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [13:0] a, e;
            a = {in_ready, busy, done, acc, f_carry, f_overflow,
                 f_negativo, f_zero};
            e = {left > 0, (left > 0) || m_done, m_done, 8'(m_acc),
                 m_c, m_v, m_acc > 127, m_acc == 0};
            check("cycle_outputs", int'(a), int'(e));
        end
        if (done) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [3:0] n);
        start = 1'b1;
        op_count = n;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] v, input bit c, input bit o);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_result = v;
        in_carry = c;
        in_overflow = o;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_carry = 1'b0;
        in_overflow = 1'b0;
    endtask

    task automatic wait_done(input int lat);
        bit ok;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("done_timeout", 0, 1);
        else if (lat >= 0) check("done_latency", cyc - start_cyc, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_acc", int'(acc), 0);
        check("rst_zero", int'(f_zero), 1);
        check("rst_busy_ready", int'({busy, in_ready, done}), 0);
        rst_n = 1'b1;
        step(2);

        // 5 + 10 + 1
        d0 = done_cnt;
        do_start(4'd3);
        feed(8'h05, 0, 0);
        feed(8'h0A, 0, 0);
        feed(8'h01, 0, 0);
        wait_done(3);
        step(2);
        check("r1_acc", int'(acc), 'h10);
        check("r1_flags", int'({f_carry, f_overflow, f_negativo, f_zero}), 0);
        check("r1_done_cnt", done_cnt - d0, 1);

        // in_valid while idle is ignored
        in_valid = 1'b1;
        in_result = 8'h33;
        step(2);
        in_valid = 1'b0;
        check("idle_valid_acc", int'(acc), 'h10);

        // 0x7F + 0x01: signed overflow, no carry
        do_start(4'd2);
        feed(8'h7F, 0, 0);
        feed(8'h01, 0, 0);
        wait_done(2);
        check("r2_acc", int'(acc), 'h80);
        check("r2_flags", int'({f_carry, f_overflow, f_negativo}), 3'b011);

        // 0xFF + 0x01: carry out, zero, no overflow
        do_start(4'd2);
        feed(8'hFF, 0, 0);
        feed(8'h01, 0, 0);
        wait_done(2);
        check("r3_acc", int'(acc), 0);
        check("r3_flags", int'({f_carry, f_overflow, f_zero}), 3'b101);

        // empty run; start held into DONE must not launch another run
        d0 = done_cnt;
        start = 1'b1;
        op_count = 4'd0;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        @(negedge clk);
        check("r4_done", int'(done), 1);
        check("r4_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        step(3);
        check("r4_done_cnt", done_cnt - d0, 1);
        check("r4_acc", int'(acc), 0);

        // gapped transfers with a stray start mid-run
        d0 = done_cnt;
        do_start(4'd4);
        feed(8'h10, 0, 0);
        step(1);
        start = 1'b1;
        op_count = 4'd2;
        step(1);
        start = 1'b0;
        step(1);
        feed(8'h20, 0, 0);
        step(3);
        feed(8'h30, 0, 0);
        step(3);
        feed(8'h40, 0, 0);
        wait_done(-1);
        step(3);
        check("r5_acc", int'(acc), 'hA0);
        check("r5_flags", int'({f_carry, f_overflow}), 2'b01);
        check("r5_done_cnt", done_cnt - d0, 1);

        // count above MAX_OPS is clamped
        do_start(4'd9);
        for (int i = 0; i < MAXP; i++) feed(8'h01, 0, 0);
        wait_done(MAXP);
        check("r6_acc", int'(acc), MAXP);

        // reset mid-run discards the partial sum
        do_start(4'd4);
        feed(8'h11, 0, 0);
        feed(8'h22, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("r7_acc", int'(acc), 0);
        check("r7_state", int'({busy, in_ready, done, f_carry, f_overflow}), 0);
        @(posedge clk);
        #1;

        // upstream carry/overflow are folded into the sticky flags
        do_start(4'd1);
        feed(8'h80, 1, 1);
        wait_done(1);
        check("r8_acc", int'(acc), 'h80);
        check("r8_flags", int'({f_carry, f_overflow, f_negativo}), 3'b111);
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter MAX_OPS, default 15, SHALL set the largest operand count accepted per run (1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 start  input  1  SHALL request a new run; sampled only in IDLE.
REQ-005 op_count  input  4  SHALL give the number of adder results to accumulate; sampled with start.
REQ-006 in_valid  input  1  SHALL flag that the upstream adder outputs are valid this cycle.
REQ-007 in_result  input  8  SHALL carry the adder's sign-extended 8-bit Result.
REQ-008 in_carry, in_overflow  input  1 each  SHALL carry the adder's f_carry and f_overflow.
REQ-009 in_ready  output  1  SHALL indicate that the block accepts a result this cycle.
REQ-010 acc  output  8  SHALL present the registered running sum.
REQ-011 f_carry, f_overflow  output  1 each  SHALL present sticky carry and overflow for the run.
REQ-012 f_negativo, f_zero  output  1 each  SHALL present acc[7] and (acc == 0), derived from registered acc.
REQ-013 busy, done  output  1 each  SHALL indicate a run in progress and a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-015 In IDLE with start=1 and op_count in 1..MAX_OPS: clear acc, f_carry and f_overflow, load remaining=op_count, go to ACCUM next cycle.
REQ-016 In IDLE with start=1 and op_count=0: clear acc and flags, go directly to DONE; no transfer is accepted.
REQ-017 If op_count > MAX_OPS, the count SHALL be clamped to MAX_OPS.
REQ-018 in_ready SHALL be 1 only in ACCUM; it SHALL be 0 in IDLE and DONE.
REQ-019 A transfer SHALL occur on a cycle where in_valid=1 and in_ready=1; in_valid in any other state SHALL be ignored.
REQ-020 On a transfer: acc <= (acc + in_result) mod 256; remaining <= remaining - 1.
REQ-021 On a transfer: f_carry <= f_carry | in_carry | (carry-out of the 8-bit add).
REQ-022 On a transfer: f_overflow <= f_overflow | in_overflow | (two's-complement overflow of the 8-bit add: operand signs equal, sum sign differs).
REQ-023 A transfer with remaining=1 SHALL move the FSM to DONE on the next cycle; in_ready SHALL drop in that same next cycle.
REQ-024 Cycles in ACCUM with in_valid=0 SHALL hold all state, with no timeout.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; acc and flags SHALL hold until the next accepted start.
REQ-026 busy SHALL be 1 in ACCUM and DONE and 0 in IDLE.
REQ-027 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 Latency: a run of N operands with in_valid held high SHALL assert done exactly N+1 cycles after the start cycle.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, acc=0, remaining=0, f_carry=0, f_overflow=0, in_ready=0, busy=0, done=0; as a result f_zero=1 and f_negativo=0.
REQ-030 Reset SHALL take priority over every other input, including mid-run and during DONE; a partial run SHALL be discarded.

Verification
REQ-031 Reset, then start with op_count=3; results 0x05, 0x0A, 0x01 with in_valid high -> acc=0x10, no flags set, done pulses once 4 cycles after start.
REQ-032 op_count=2; results 0x7F, 0x01 -> acc=0x80, f_overflow=1, f_negativo=1, f_carry=0.
REQ-033 op_count=2; results 0xFF, 0x01 -> acc=0x00, f_carry=1, f_zero=1, f_overflow=0.
REQ-034 op_count=0 -> done pulses on the cycle after start, in_ready never asserts, acc=0x00.
REQ-035 op_count=4, in_valid gapped 3 cycles between transfers, start re-asserted mid-run -> start ignored, final sum correct, a single done pulse.
REQ-036 rst_n low after 2 of 4 transfers -> next cycle IDLE, acc=0x00, flags 0; a new run then completes normally.
